// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register bank slave: single-beat writes/reads into a window of
// 32-bit registers at BASE_ADDR. Register 0 is a read-only ID constant.
module axi_lite_reg_responder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h6000_0000,
  parameter int unsigned        NUM_REGS  = 16,
  parameter logic [31:0]        ID_VALUE  = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // write address
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [ADDR_W-1:0]      s_awaddr,
  // write data
  input  logic                   s_wvalid,
  output logic                   s_wready,
  input  logic [DATA_W-1:0]      s_wdata,
  input  logic [3:0]             s_wstrb,
  // write response
  output logic                   s_bvalid,
  input  logic                   s_bready,
  output logic [1:0]             s_bresp,
  // read address
  input  logic                   s_arvalid,
  output logic                   s_arready,
  input  logic [ADDR_W-1:0]      s_araddr,
  // read data
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  // register contents
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int unsigned       IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] WIN_MASK = ~(ADDR_W'(NUM_REGS * 4) - ADDR_W'(1));
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  // One-entry holding registers for AW and W
  logic                aw_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic                w_held;
  logic [DATA_W-1:0]   w_data_q;
  logic [3:0]          w_strb_q;

  // Register 0 is the ID constant and has no storage
  logic [31:0]         regs_q [1:NUM_REGS-1];

  logic                aw_hs, w_hs, ar_hs;
  logic                commit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [3:0]          wr_strb;
  logic                wr_hit, wr_ok;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_hit;
  logic [IDX_W-1:0]    rd_idx;
  logic [31:0]         rd_val;

  // Readys depend only on state, never on any valid
  assign s_awready = !aw_held && !s_bvalid;
  assign s_wready  = !w_held && !s_bvalid;
  assign s_arready = !s_rvalid;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Commit as soon as both halves are available, held or arriving this cycle
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr_q : s_awaddr;
  assign wr_data = w_held ? w_data_q : s_wdata;
  assign wr_strb = w_held ? w_strb_q : s_wstrb;

  assign wr_hit = (wr_addr & WIN_MASK) == BASE_ADDR;
  assign wr_idx = wr_addr[2 +: IDX_W];
  assign wr_ok  = wr_hit && (wr_idx != '0);

  assign rd_hit = (s_araddr & WIN_MASK) == BASE_ADDR;
  assign rd_idx = s_araddr[2 +: IDX_W];

  // Read mux; sees pre-commit register values
  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      rd_val = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_idx == IDX_W'(i)) rd_val = regs_q[i];
      end
    end
  end

  // Capture AW/W independently; both drop at commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
    end
  end

  // Write response: raised at commit, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_bvalid <= 1'b1;
      s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_bvalid && s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

  // Read response: captured at AR handshake, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= DATA_W'(rd_val);
      s_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  // Byte-strobed register update on a good commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Flatten register bank, ID constant in slot 0
  always_comb begin
    regs_o = '0;
    regs_o[31:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs_q[i];
  end

endmodule
